// File: rtl/mux_4to1.sv
// 4:1 multiplexer with a combinational output and a registered, valid-qualified copy.
module mux_4to1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [1:0]       sel_q,
  output logic             out_valid
);

  // Select one data input; an unknown select yields all-X rather than a silent pick.
  always_comb begin
    y = {WIDTH{1'bx}};
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      2'b11:   y = d3;
      default: y = {WIDTH{1'bx}};
    endcase
  end

  // Capture the selected value on valid input; hold otherwise, valid pulses one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      sel_q     <= 2'b00;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      y_q       <= y;
      sel_q     <= sel;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Scoreboard bench for mux_4to1: directed cases followed by randomized traffic.
module tb_mux_4to1;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   sel;
  logic [W-1:0] d0, d1, d2, d3;
  logic [W-1:0] y, y_q;
  logic [1:0]   sel_q;
  logic         out_valid;
  logic         y1, y1_q;
  logic [1:0]   sel1_q;
  logic         out_valid1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];

  mux_4to1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .in_valid(in_valid),
    .y(y), .y_q(y_q), .sel_q(sel_q), .out_valid(out_valid)
  );

  mux_4to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel),
    .d0(d0[0]), .d1(d1[0]), .d2(d2[0]), .d3(d3[0]),
    .in_valid(in_valid),
    .y(y1), .y_q(y1_q), .sel_q(sel1_q), .out_valid(out_valid1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick the input whose index equals sel; unknown sel gives unknown output.
  function automatic logic [W-1:0] ref_y(input logic [1:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] c,
                                         input logic [W-1:0] e);
    logic [W-1:0] v [4];
    v = '{a, b, c, e};
    if ($isunknown(s)) return {W{1'bx}};
    return v[s];
  endfunction

  // Apply one cycle of stimulus, queue the expected capture, check the combinational path.
  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] e);
    logic [W-1:0] ey;
    @(negedge clk);
    rst = r; in_valid = v; sel = s;
    d0 = a; d1 = b; d2 = c; d3 = e;
    ey = ref_y(sel, d0, d1, d2, d3);
    if (v && !r) sb.push_back('{sel: sel, data: ey});
    #1;
    chk("y", 64'(y), 64'(ey));
    chk("y_w1", 64'(y1), 64'(ey[0]));
  endtask

  // Monitor: pop an expectation whenever a capture is presented, otherwise check hold.
  initial begin
    logic         r_now;
    logic [W-1:0] held;
    logic [1:0]   hsel;
    exp_t         e;
    held = '0;
    hsel = 2'b00;
    forever begin
      @(posedge clk);
      r_now = rst;
      #1;
      if (r_now) begin
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_y_q", 64'(y_q), 64'(0));
        chk("rst_sel_q", 64'(sel_q), 64'(0));
        chk("rst_w1", 64'({out_valid1, y1_q, sel1_q}), 64'(0));
        held = '0;
        hsel = 2'b00;
        sb.delete();
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("y_q", 64'(y_q), 64'(e.data));
          chk("sel_q", 64'(sel_q), 64'(e.sel));
          chk("y_q_w1", 64'(y1_q), 64'(e.data[0]));
          chk("sel_q_w1", 64'(sel1_q), 64'(e.sel));
          chk("out_valid_w1", 64'(out_valid1), 64'(1));
          held = e.data;
          hsel = e.sel;
        end
      end else begin
        chk("missing_out_valid", 64'(sb.size()), 64'(0));
        if (sb.size() != 0) void'(sb.pop_front());
        chk("hold_y_q", 64'(y_q), 64'(held));
        chk("hold_sel_q", 64'(sel_q), 64'(hsel));
        chk("hold_w1", 64'({out_valid1, y1_q, sel1_q}), 64'({1'b0, held[0], hsel}));
      end
    end
  end

  // Stimulus: directed cases, then random traffic with occasional resets.
  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 2'b00;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // 0/1/0/1 pattern swept with in_valid high every cycle
    for (int s = 0; s < 4; s++)
      drive(1'b0, 1'b1, 2'(s), 8'h00, 8'h01, 8'h00, 8'h01);

    // reset wins over in_valid
    drive(1'b1, 1'b1, 2'b01, 8'h00, 8'h01, 8'h00, 8'h01);
    drive(1'b0, 1'b0, 2'b01, 8'h00, 8'h01, 8'h00, 8'h01);

    // capture sel=11 then hold for three idle cycles while sel moves
    drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h01, 8'h00, 8'h01);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 2'(i), 8'h00, 8'h01, 8'h00, 8'h01);

    // 8-bit sweep
    for (int s = 0; s < 4; s++)
      drive(1'b0, 1'b1, 2'(s), 8'h00, 8'hA5, 8'h5A, 8'hFF);

    // data change with sel stable reaches y now, y_q only on next capture
    drive(1'b0, 1'b0, 2'b01, 8'h00, 8'hA5, 8'h5A, 8'hFF);
    drive(1'b0, 1'b0, 2'b01, 8'h00, 8'h3C, 8'h5A, 8'hFF);
    drive(1'b0, 1'b1, 2'b01, 8'h00, 8'hC3, 8'h5A, 8'hFF);

    // rst does not disturb the combinational output
    drive(1'b1, 1'b0, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);

    // unknown select
    drive(1'b0, 1'b0, 2'bx0, 8'h11, 8'h22, 8'h33, 8'h44);
    drive(1'b0, 1'b0, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44);

    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7), 2'($urandom),
            W'($urandom), W'($urandom), W'($urandom), W'($urandom));

    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
